// File: rtl/heepsilon_pkg.sv
// Shared CGRA/X-HEEP integration constants and OBI bundle types.
package heepsilon_pkg;
   localparam int CGRA_XBAR_NMASTER        = 4;
   localparam int LOG_EXT_XBAR_NMASTER     = $clog2(CGRA_XBAR_NMASTER);
   localparam int CGRA_ARB_MAX_OUTSTANDING = 4;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cgra_obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } cgra_obi_resp_t;
endpackage

// File: rtl/cgra_arb_id_fifo.sv
// In-order FIFO of granted column indices; the head names the column that owns the next response.
module cgra_arb_id_fifo #(
   parameter int W     = 2,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  wdata_i,
   output logic [W-1:0]  rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0][W-1:0] mem_q;
   logic [PW-1:0]           wptr_q, rptr_q;
   logic [CW-1:0]           count_q;
   logic                    do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
            wptr_q        <= ptr_inc(wptr_q);
         end
         if (do_pop) rptr_q <= ptr_inc(rptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/cgra_obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI master port among the CGRA columns; responses are
// routed back in issue order through an ID FIFO.
module cgra_obi_rr_arbiter
   import heepsilon_pkg::*;
#(
   parameter int NMASTER         = CGRA_XBAR_NMASTER,
   parameter int MAX_OUTSTANDING = CGRA_ARB_MAX_OUTSTANDING,
   parameter int AW              = 32,
   parameter int DW              = 32
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NMASTER-1:0]                m_req_i,
   input  logic [NMASTER-1:0]                m_we_i,
   input  logic [NMASTER-1:0][DW/8-1:0]      m_be_i,
   input  logic [NMASTER-1:0][AW-1:0]        m_addr_i,
   input  logic [NMASTER-1:0][DW-1:0]        m_wdata_i,
   output logic [NMASTER-1:0]                m_gnt_o,
   output logic [NMASTER-1:0]                m_rvalid_o,
   output logic [NMASTER-1:0][DW-1:0]        m_rdata_o,
   output logic                              s_req_o,
   output logic                              s_we_o,
   output logic [DW/8-1:0]                   s_be_o,
   output logic [AW-1:0]                     s_addr_o,
   output logic [DW-1:0]                     s_wdata_o,
   input  logic                              s_gnt_i,
   input  logic                              s_rvalid_i,
   input  logic [DW-1:0]                     s_rdata_i,
   output logic                              busy_o,
   output logic                              err_o
);
   localparam int IW = LOG_EXT_XBAR_NMASTER;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   logic [IW-1:0] rr_ptr_q, rr_ptr_d, lidx_q, lidx_d;
   logic          lock_q, lock_d, err_q, err_d;
   logic [IW-1:0] chosen, scan_idx, head;
   logic          found, sel_vld, chosen_vld, viol, sreq, hs, pop;
   logic          full, empty;
   logic [CW-1:0] count;

   always_comb begin
      found    = 1'b0;
      chosen   = '0;
      scan_idx = '0;
      for (int i = 0; i < NMASTER; i++) begin
         scan_idx = IW'((int'(rr_ptr_q) + i) % NMASTER);
         if (!found && m_req_i[scan_idx]) begin
            found  = 1'b1;
            chosen = scan_idx;
         end
      end
      // Held address phase: the locked column keeps the port until its handshake.
      if (lock_q) chosen = lidx_q;
   end

   assign sel_vld    = (lock_q | found) & ~rst_i;
   assign chosen_vld = lock_q ? m_req_i[lidx_q] : found;
   assign viol       = lock_q & ~m_req_i[lidx_q];
   assign sreq       = chosen_vld & ~full;
   assign hs         = sreq & s_gnt_i;
   assign pop        = s_rvalid_i & ~empty;

   assign s_req_o   = sreq & ~rst_i;
   assign s_we_o    = sel_vld ? m_we_i[chosen]    : 1'b0;
   assign s_be_o    = sel_vld ? m_be_i[chosen]    : '0;
   assign s_addr_o  = sel_vld ? m_addr_i[chosen]  : '0;
   assign s_wdata_o = sel_vld ? m_wdata_i[chosen] : '0;
   assign m_rdata_o = {NMASTER{rst_i ? {DW{1'b0}} : s_rdata_i}};
   assign busy_o    = ~rst_i & ((count != '0) | (|m_req_i));
   assign err_o     = err_q;

   always_comb begin
      m_gnt_o    = '0;
      m_rvalid_o = '0;
      for (int i = 0; i < NMASTER; i++) begin
         m_gnt_o[i]    = hs & ~rst_i & (chosen == IW'(i));
         m_rvalid_o[i] = pop & ~rst_i & (head == IW'(i));
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      lock_d   = lock_q;
      lidx_d   = lidx_q;
      err_d    = err_q | (s_rvalid_i & empty) | viol;
      if (hs) begin
         rr_ptr_d = (chosen == IW'(NMASTER - 1)) ? '0 : chosen + 1'b1;
         lock_d   = 1'b0;
      end else if (viol) begin
         lock_d = 1'b0;
      end else if (sreq) begin
         lock_d = 1'b1;
         lidx_d = chosen;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
         lock_q   <= 1'b0;
         lidx_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         lock_q   <= lock_d;
         lidx_q   <= lidx_d;
         err_q    <= err_d;
      end
   end

   cgra_arb_id_fifo #(.W(IW), .DEPTH(MAX_OUTSTANDING), .CW(CW)) u_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (hs),
      .pop_i   (pop),
      .wdata_i (chosen),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );
endmodule

// File: tb/tb_cgra_obi_rr_arbiter.sv
// Directed and randomized checks of the CGRA OBI round-robin arbiter against a queue-based model.
module tb_cgra_obi_rr_arbiter;
   localparam int N  = 4;
   localparam int MO = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic [N-1:0]        m_req, m_we, m_gnt, m_rvalid;
   logic [N-1:0][3:0]   m_be;
   logic [N-1:0][31:0]  m_addr, m_wdata, m_rdata;
   logic                s_req, s_we, s_gnt, s_rvalid, busy, err;
   logic [3:0]          s_be;
   logic [31:0]         s_addr, s_wdata, s_rdata;

   cgra_obi_rr_arbiter #(.NMASTER(N), .MAX_OUTSTANDING(MO), .AW(32), .DW(32)) dut (
      .clk_i(clk), .rst_i(rst),
      .m_req_i(m_req), .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
      .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
      .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
      .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
      .busy_o(busy), .err_o(err)
   );

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;
   int mptr, mlock;
   int mq[$];
   bit merr;
   logic [N-1:0]       o_gnt, o_rv;
   logic               o_sreq, o_busy, o_err;
   logic [31:0]        o_addr;
   logic [N-1:0][31:0] o_rdata;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mptr = 0; mlock = -1; mq.delete(); merr = 0;
   endtask

   task automatic do_reset();
      m_req = '0; s_gnt = 0; s_rvalid = 0; s_rdata = '0;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      model_reset();
   endtask

   // One clock: drive, check every output against the model, clock, advance the model.
   task automatic cycle(input logic [N-1:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
      int ch;
      logic any, full, sreq, hs;
      logic [N-1:0] egnt, erv;
      m_req = req; s_gnt = gnt; s_rvalid = rv; s_rdata = rd;
      #1;
      any  = |req;
      full = (mq.size() == MO);
      ch   = -1;
      if (mlock >= 0) ch = mlock;
      else for (int i = 0; i < N; i++) if (ch < 0 && req[(mptr + i) % N]) ch = (mptr + i) % N;
      sreq = ((mlock >= 0) ? req[mlock] : any) && !full;
      hs   = sreq && gnt;
      egnt = hs ? (4'b0001 << ch) : 4'b0000;
      erv  = (rv && mq.size() > 0) ? (4'b0001 << mq[0]) : 4'b0000;
      chk("s_req", s_req, sreq);
      chk("m_gnt", m_gnt, egnt);
      chk("m_rvalid", m_rvalid, erv);
      chk("s_addr", s_addr, (ch >= 0) ? m_addr[ch] : 32'h0);
      chk("s_wdata", s_wdata, (ch >= 0) ? m_wdata[ch] : 32'h0);
      chk("s_we_be", {s_we, s_be}, (ch >= 0) ? {m_we[ch], m_be[ch]} : 5'h0);
      chk("m_rdata", m_rdata, {N{rd}});
      chk("busy", busy, (mq.size() != 0) || any);
      chk("err", err, merr);
      o_gnt = m_gnt; o_rv = m_rvalid; o_sreq = s_req; o_busy = busy;
      o_addr = s_addr; o_rdata = m_rdata; o_err = err;
      @(posedge clk); #1;
      if (rv) begin
         if (mq.size() > 0) void'(mq.pop_front());
         else merr = 1;
      end
      if (hs) begin
         mq.push_back(ch); mptr = (ch + 1) % N; mlock = -1;
      end else if (mlock >= 0 && !req[mlock]) begin
         mlock = -1; merr = 1;
      end else if (sreq) begin
         mlock = ch;
      end
   endtask

   function automatic int onehot_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   initial begin
      int order[$];
      int exp_ord[6];
      int ngnt;
      m_we = '0; m_be = '0; m_wdata = '0;
      for (int c = 0; c < N; c++) begin
         m_addr[c]  = 32'hF000_0000 + 32'(c) * 32'h20;
         m_wdata[c] = 32'hA000_0000 + 32'(c);
         m_be[c]    = 4'hF;
      end
      m_addr[2] = 32'hF000_0040;
      do_reset();
      #1;
      chk("rst_sreq", s_req, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      @(posedge clk); #1;

      // Single read from column 2.
      cycle(4'b0100, 1, 0, 32'h0);
      chk("t1_gnt", o_gnt, 4'b0100);
      chk("t1_addr", o_addr, 32'hF000_0040);
      cycle(4'b0000, 0, 0, 32'h0);
      cycle(4'b0000, 0, 1, 32'hDEAD_BEEF);
      chk("t1_rvalid", o_rv, 4'b0100);
      chk("t1_rdata", o_rdata[2], 32'hDEAD_BEEF);
      chk("t1_busy_resp", o_busy, 1'b1);
      cycle(4'b0000, 0, 0, 32'h0);
      chk("t1_busy_after", o_busy, 1'b0);

      // All columns streaming; round-robin order and in-order responses.
      do_reset();
      exp_ord = '{0, 1, 2, 3, 0, 1};
      for (int k = 0; k < 7; k++) begin
         cycle((k < 6) ? 4'b1111 : 4'b0000, 1, (k > 0), $urandom);
         if (k > 0) chk($sformatf("t2_rv%0d", k), o_rv, 4'b0001 << order[k-1]);
         if (k < 6) order.push_back(onehot_idx(o_gnt));
      end
      for (int k = 0; k < 6; k++) chk($sformatf("t2_ord%0d", k), order[k], exp_ord[k]);

      // Stalled address phase holds column 1 against column 0.
      do_reset();
      cycle(4'b0010, 0, 0, 32'h0);
      chk("t3_addr0", o_addr, m_addr[1]);
      cycle(4'b0011, 0, 0, 32'h0);
      chk("t3_addr1", o_addr, m_addr[1]);
      cycle(4'b0011, 0, 0, 32'h0);
      chk("t3_addr2", o_addr, m_addr[1]);
      cycle(4'b0011, 1, 0, 32'h0);
      chk("t3_gnt1", o_gnt, 4'b0010);
      cycle(4'b0001, 1, 1, 32'h1111);
      chk("t3_gnt0", o_gnt, 4'b0001);
      chk("t3_rv1", o_rv, 4'b0010);
      cycle(4'b0000, 0, 1, 32'h2222);
      chk("t3_rv0", o_rv, 4'b0001);

      // Outstanding limit.
      do_reset();
      ngnt = 0;
      for (int k = 0; k < 5; k++) begin
         cycle(4'b0001, 1, 0, 32'h0);
         if (o_gnt != 0) ngnt++;
      end
      chk("t4_ngnt", ngnt, 4);
      chk("t4_full_req", o_sreq, 1'b0);
      cycle(4'b0001, 1, 1, 32'h0);
      chk("t4_pop_noreq", o_sreq, 1'b0);
      cycle(4'b0001, 1, 0, 32'h0);
      chk("t4_reassert", o_sreq, 1'b1);
      for (int k = 0; k < 4; k++) cycle(4'b0000, 0, 1, $urandom);

      // Stray response sets the sticky error.
      do_reset();
      cycle(4'b0000, 0, 1, 32'h0);
      chk("t5_rv", o_rv, 4'b0000);
      for (int k = 0; k < 3; k++) cycle(4'b0001, 1, (k == 1), 32'h0);
      chk("t5_err_sticky", o_err, 1'b1);
      do_reset();
      #1;
      chk("t5_err_clr", err, 1'b0);
      @(posedge clk); #1;

      // Reset with three outstanding and a locked request.
      cycle(4'b0001, 1, 0, 32'h0);
      cycle(4'b0010, 1, 0, 32'h0);
      cycle(4'b0100, 1, 0, 32'h0);
      cycle(4'b0001, 0, 0, 32'h0);
      m_req = 4'b1111; s_gnt = 1; s_rvalid = 1; s_rdata = 32'hFFFF_FFFF;
      #1;
      rst = 1'b1;
      #1;
      chk("t6_sreq", s_req, 1'b0);
      chk("t6_gnt", m_gnt, 4'b0000);
      chk("t6_rv", m_rvalid, 4'b0000);
      chk("t6_addr", s_addr, 32'h0);
      chk("t6_rdata", m_rdata, 128'h0);
      chk("t6_busy_err", {busy, err}, 2'b00);
      m_req = '0; s_gnt = 0; s_rvalid = 0; s_rdata = '0;
      #1;
      rst = 1'b0;
      model_reset();
      cycle(4'b1000, 1, 0, 32'h0);
      chk("t6_gnt3", o_gnt, 4'b1000);
      cycle(4'b1001, 1, 1, 32'h0);
      chk("t6_gnt0", o_gnt, 4'b0001);
      cycle(4'b0000, 0, 1, 32'h0);

      // Randomized traffic against the model.
      do_reset();
      for (int k = 0; k < 600; k++) begin
         logic [N-1:0] rq;
         logic rv;
         for (int c = 0; c < N; c++) begin
            if (c == mlock) rq[c] = 1'b1;
            else begin
               rq[c]      = ($urandom_range(0, 2) != 0);
               m_addr[c]  = $urandom;
               m_wdata[c] = $urandom;
               m_we[c]    = $urandom_range(0, 1);
               m_be[c]    = 4'($urandom_range(0, 15));
            end
         end
         rv = (mq.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
         cycle(rq, ($urandom_range(0, 3) != 0), rv, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
